wshb_arbiter_prio: RTL
======================

Name: wshb_arbiter_prio

Overview:
- Two-master Wishbone arbiter sharing the SDRAM Wishbone port between the VGA frame reader (priority master) and the pattern generator "mire" (background master).
- Gives the VGA low-latency access.
- Bounds mire occupancy with an ack quota, and preempts mire only at transfer boundaries so that SDRAM bursts are never broken.
- Sits between both masters and the SDRAM controller; all interfaces are synchronous to clk.

Parameters:
- MIRE_QUANTUM, 16, number of mire acks allowed per grant before a pending VGA request may preempt; legal range 1..255.
- CNT_W, 8, width of the quota counter; must satisfy 2**CNT_W > MIRE_QUANTUM.

Ports:
- clk  input  1  system clock, same as the SDRAM clock.
- rst  input  1  asynchronous active-high reset.
- wshb_ifs_vga  wshb_if.slave  bundle  VGA master side (cyc, stb, adr, we, sel, cti, bte, dat_ms in; ack, err, rty, dat_sm out).
- wshb_ifs_mire  wshb_if.slave  bundle  mire master side, same signal set.
- wshb_ifm_sdram  wshb_if.master  bundle  SDRAM controller side.
- vga_urgent  input  1  VGA FIFO below its low-water mark; requests preemption regardless of the quota.
- grant_vga  output  1  registered, high while the VGA owns the bus.
- grant_mire  output  1  registered, high while mire owns the bus.

Behaviour:
- Owner register with states IDLE, VGA, MIRE.
  - Reset: IDLE, quota counter = 0, grant_vga = grant_mire = 0.
- Muxing is combinational from the owner register.
  - IDLE: sdram cyc = stb = we = 0; adr, dat_ms, sel, cti, bte = 0.
  - VGA or MIRE: all request fields are driven from the owner's master.
  - The non-owner always sees ack = err = rty = 0 and dat_sm = 0.
  - The owner sees sdram ack/err/rty/dat_sm unchanged.
- IDLE transitions:
  - vga.cyc → VGA next edge.
  - else mire.cyc → MIRE next edge, quota counter cleared.
  - If both request in the same cycle, VGA wins.
- Grant latency: request sampled at edge N; sdram cyc is visible in cycle N+1.
- VGA state: held while vga.cyc = 1. When vga.cyc = 0 → IDLE. No quota applies to VGA.
- MIRE state:
  - The counter increments on each sdram ack and saturates at MIRE_QUANTUM.
  - Transfer boundary = a cycle with sdram ack = 1 (or err/rty = 1) and mire.cti ∈ {3'b000, 3'b111}.
  - At a boundary, if vga.cyc = 1 and (counter+1 ≥ MIRE_QUANTUM or vga_urgent = 1) → IDLE (preemption).
  - mire.cyc = 0 → IDLE at any time.
  - A preempted mire keeps cyc/stb high and simply sees no ack until it is re-granted. This is a legal Wishbone wait state. Its next request is re-sampled in IDLE, where VGA priority applies.
- Every owner change passes through IDLE for at least one cycle. This gives a mandatory dead cycle with sdram cyc = 0, closing the previous Wishbone cycle at the SDRAM controller.
- No preemption in the middle of an incrementing burst (cti = 3'b010), even with vga_urgent = 1.
- grant_vga and grant_mire are the registered state decode; they are mutually exclusive.
- Reset mid-transfer: owner goes to IDLE asynchronously; sdram cyc/stb fall without waiting for a clock.

Test Plan:
- Reset with both cyc = 1 → sdram cyc = 0 during reset; first edge after release → grant_vga = 1, and sdram adr equals the VGA adr in the next cycle.
- Mire alone, 40 classic single reads (cti = 000), VGA idle → no dead cycle inserted, 40 acks routed to mire, VGA ack stays 0 throughout.
- MIRE_QUANTUM = 16, mire streaming classic reads, VGA raises cyc after mire ack #3 → mire completes acks #4..#16, then one IDLE cycle, then grant_vga = 1; mire sees no ack until VGA drops cyc.
- Mire in an 8-beat burst (cti = 010, last beat 111), vga_urgent = 1 asserted at beat 2 → preemption happens only after the beat-8 ack with cti = 111; VGA is granted 2 cycles later.
- VGA and mire both assert cyc on the same edge from IDLE → VGA granted; when VGA drops cyc, one dead cycle follows, then grant_mire = 1 with the quota counter = 0.
- Asynchronous rst pulse mid-way through a VGA burst (between edges) → sdram cyc = 0 and grant_vga = 0 immediately; after release, arbitration restarts from IDLE.

Source files
------------

// File: rtl/wshb_arbiter_prio_if.sv
// Wishbone bus bundle shared by the arbiter ports and the bench.
// master drives the request fields; slave returns ack/err/rty/dat_sm.
interface wshb_if #(
   parameter int DW = 32,
   parameter int AW = 32
);
   logic            cyc;
   logic            stb;
   logic            we;
   logic [AW-1:0]   adr;
   logic [DW/8-1:0] sel;
   logic [2:0]      cti;
   logic [1:0]      bte;
   logic [DW-1:0]   dat_ms;
   logic [DW-1:0]   dat_sm;
   logic            ack;
   logic            err;
   logic            rty;

   modport master (
      output cyc, stb, we, adr, sel, cti, bte, dat_ms,
      input  ack, err, rty, dat_sm
   );

   modport slave (
      input  cyc, stb, we, adr, sel, cti, bte, dat_ms,
      output ack, err, rty, dat_sm
   );
endinterface

// File: rtl/wshb_arbiter_prio.sv
// Two-master Wishbone arbiter in front of the SDRAM controller.
// The VGA reader has priority; the pattern generator (mire) is bounded by
// an ack quota and is only preempted on a transfer boundary, so SDRAM
// bursts are never cut. Every owner change passes through IDLE, giving one
// dead cycle with sdram cyc low to close the previous Wishbone cycle.
module wshb_arbiter_prio #(
   parameter int MIRE_QUANTUM = 16,
   parameter int CNT_W        = 8
) (
   input  logic   clk,
   input  logic   rst,
   wshb_if.slave  wshb_ifs_vga,
   wshb_if.slave  wshb_ifs_mire,
   wshb_if.master wshb_ifm_sdram,
   input  logic   vga_urgent,
   output logic   grant_vga,
   output logic   grant_mire
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_VGA  = 2'd1,
      ST_MIRE = 2'd2
   } owner_t;

   // Quantum at counter width (saturation value) and one bit wider, so the
   // "counter + 1" comparison cannot wrap when the quantum is near 2**CNT_W.
   localparam logic [CNT_W-1:0] QUANTUM_C = CNT_W'(MIRE_QUANTUM);
   localparam logic [CNT_W:0]   QUANTUM_W = (CNT_W+1)'(MIRE_QUANTUM);

   owner_t           owner_q;
   logic [CNT_W-1:0] quota_q;
   logic             grant_vga_q;
   logic             grant_mire_q;

   logic             mire_term;
   logic             mire_last_beat;
   logic             mire_boundary;
   logic             quota_spent;
   logic             mire_preempt;

   // Preemption decision: only when a mire transfer completes on a
   // classic cycle or the last beat of a burst, never mid-burst.
   always_comb begin
      mire_term      = wshb_ifm_sdram.ack | wshb_ifm_sdram.err | wshb_ifm_sdram.rty;
      mire_last_beat = (wshb_ifs_mire.cti == 3'b000) || (wshb_ifs_mire.cti == 3'b111);
      mire_boundary  = mire_term && mire_last_beat;
      quota_spent    = (({1'b0, quota_q} + (CNT_W+1)'(1)) >= QUANTUM_W);
      mire_preempt   = mire_boundary && wshb_ifs_vga.cyc && (quota_spent || vga_urgent);
   end

   // Owner FSM with registered grant decode; async reset drops the owner
   // straight to IDLE so the SDRAM side releases cyc/stb without a clock.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         owner_q      <= ST_IDLE;
         quota_q      <= '0;
         grant_vga_q  <= 1'b0;
         grant_mire_q <= 1'b0;
      end else begin
         case (owner_q)
            ST_IDLE: begin
               if (wshb_ifs_vga.cyc) begin
                  owner_q      <= ST_VGA;
                  grant_vga_q  <= 1'b1;
                  grant_mire_q <= 1'b0;
               end else if (wshb_ifs_mire.cyc) begin
                  owner_q      <= ST_MIRE;
                  grant_vga_q  <= 1'b0;
                  grant_mire_q <= 1'b1;
                  quota_q      <= '0;
               end
            end
            ST_VGA: begin
               if (!wshb_ifs_vga.cyc) begin
                  owner_q     <= ST_IDLE;
                  grant_vga_q <= 1'b0;
               end
            end
            ST_MIRE: begin
               if (wshb_ifm_sdram.ack && (quota_q != QUANTUM_C)) begin
                  quota_q <= quota_q + CNT_W'(1);
               end
               if (!wshb_ifs_mire.cyc || mire_preempt) begin
                  owner_q      <= ST_IDLE;
                  grant_mire_q <= 1'b0;
               end
            end
            default: begin
               owner_q      <= ST_IDLE;
               grant_vga_q  <= 1'b0;
               grant_mire_q <= 1'b0;
            end
         endcase
      end
   end

   assign grant_vga  = grant_vga_q;
   assign grant_mire = grant_mire_q;

   // Bus mux driven from the owner register: the owner's request goes to
   // the SDRAM, responses go back only to the owner, everything else is 0.
   always_comb begin
      wshb_ifm_sdram.cyc    = 1'b0;
      wshb_ifm_sdram.stb    = 1'b0;
      wshb_ifm_sdram.we     = 1'b0;
      wshb_ifm_sdram.adr    = '0;
      wshb_ifm_sdram.sel    = '0;
      wshb_ifm_sdram.cti    = '0;
      wshb_ifm_sdram.bte    = '0;
      wshb_ifm_sdram.dat_ms = '0;
      wshb_ifs_vga.ack      = 1'b0;
      wshb_ifs_vga.err      = 1'b0;
      wshb_ifs_vga.rty      = 1'b0;
      wshb_ifs_vga.dat_sm   = '0;
      wshb_ifs_mire.ack     = 1'b0;
      wshb_ifs_mire.err     = 1'b0;
      wshb_ifs_mire.rty     = 1'b0;
      wshb_ifs_mire.dat_sm  = '0;
      case (owner_q)
         ST_VGA: begin
            wshb_ifm_sdram.cyc    = wshb_ifs_vga.cyc;
            wshb_ifm_sdram.stb    = wshb_ifs_vga.stb;
            wshb_ifm_sdram.we     = wshb_ifs_vga.we;
            wshb_ifm_sdram.adr    = wshb_ifs_vga.adr;
            wshb_ifm_sdram.sel    = wshb_ifs_vga.sel;
            wshb_ifm_sdram.cti    = wshb_ifs_vga.cti;
            wshb_ifm_sdram.bte    = wshb_ifs_vga.bte;
            wshb_ifm_sdram.dat_ms = wshb_ifs_vga.dat_ms;
            wshb_ifs_vga.ack      = wshb_ifm_sdram.ack;
            wshb_ifs_vga.err      = wshb_ifm_sdram.err;
            wshb_ifs_vga.rty      = wshb_ifm_sdram.rty;
            wshb_ifs_vga.dat_sm   = wshb_ifm_sdram.dat_sm;
         end
         ST_MIRE: begin
            wshb_ifm_sdram.cyc    = wshb_ifs_mire.cyc;
            wshb_ifm_sdram.stb    = wshb_ifs_mire.stb;
            wshb_ifm_sdram.we     = wshb_ifs_mire.we;
            wshb_ifm_sdram.adr    = wshb_ifs_mire.adr;
            wshb_ifm_sdram.sel    = wshb_ifs_mire.sel;
            wshb_ifm_sdram.cti    = wshb_ifs_mire.cti;
            wshb_ifm_sdram.bte    = wshb_ifs_mire.bte;
            wshb_ifm_sdram.dat_ms = wshb_ifs_mire.dat_ms;
            wshb_ifs_mire.ack     = wshb_ifm_sdram.ack;
            wshb_ifs_mire.err     = wshb_ifm_sdram.err;
            wshb_ifs_mire.rty     = wshb_ifm_sdram.rty;
            wshb_ifs_mire.dat_sm  = wshb_ifm_sdram.dat_sm;
         end
         default: begin
         end
      endcase
   end

endmodule
